ch_mux_seq: RTL and testbench

Sequencer that drives the select of the 8:1 16-bit channel multiplexer (ch_mux) feeding the sample FIFO. On each sample strobe from the DDC/decimation stage it scans channels 0..numch-1, one per clock. It issues a write-enable, a one-hot channel tag and first/last markers aligned with the mux output. It also flags strobes that arrive while a scan is still in progress.

---
 rtl/ch_mux_pkg.sv | 33 +++
 rtl/ch_mux_seq.sv | 92 +++++++++
 tb/tb_ch_mux_seq.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ch_mux_pkg.sv
// Shared definitions for the 8:1 channel mux and its scan sequencer:
// sizing constants, the sequencer state type and the channel-count clamp.
package ch_mux_pkg;

  localparam int NUM_CH_MAX = 8;
  localparam int SEL_W      = $clog2(NUM_CH_MAX);
  localparam int NUMCH_W    = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Force a requested channel count into the legal range 1..NUM_CH_MAX.
  // Zero becomes one channel; anything above the mux width saturates.
  function automatic logic [NUMCH_W-1:0] clamp_numch(input logic [NUMCH_W-1:0] n);
    logic [NUMCH_W-1:0] result;
    if (n == '0) begin
      result = NUMCH_W'(1);
    end else if (n > NUMCH_W'(NUM_CH_MAX)) begin
      result = NUMCH_W'(NUM_CH_MAX);
    end else begin
      result = n;
    end
    return result;
  endfunction

  // One-hot tag for a mux select value.
  function automatic logic [NUM_CH_MAX-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    return NUM_CH_MAX'(1) << s;
  endfunction

endpackage

// File: rtl/ch_mux_seq.sv
// Channel-scan sequencer for the 8:1 sample mux. Each accepted strobe walks
// sel through 0..numch_lat-1, one channel per clock, with a FIFO write enable,
// one-hot channel tag and first/last markers aligned to the mux output.
// Strobes that land mid-scan are dropped and flagged in a sticky overrun bit.
module ch_mux_seq
  import ch_mux_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  strobe,
  input  logic [NUMCH_W-1:0]    numch,
  input  logic                  clr_ovr,
  output logic [SEL_W-1:0]      sel,
  output logic                  wr_en,
  output logic [NUM_CH_MAX-1:0] channel,
  output logic                  first,
  output logic                  last,
  output logic                  busy,
  output logic                  overrun
);

  state_t             state;
  logic [NUMCH_W-1:0] numch_lat;
  logic               at_last;
  logic               ovr_set;

  // The word on the mux this cycle is the final one of the current scan.
  assign at_last = (NUMCH_W'(sel) == (numch_lat - NUMCH_W'(1)));

  // A strobe during a scan is accepted only when it coincides with the last
  // word; any earlier strobe is lost.
  assign ovr_set = (state == SCAN) && strobe && !at_last;

  // Scan FSM, channel counter, latched channel count and sticky overrun.
  // NOTE: every register here is updated with non-blocking assignments so all
  // of them see the same pre-edge values of sel/state, regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      wr_en     <= 1'b0;
      numch_lat <= NUMCH_W'(1);
      overrun   <= 1'b0;
    end else begin
      // Setting wins over clearing so a drop in the clear cycle is not lost.
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (strobe) begin
            numch_lat <= clamp_numch(numch);
            sel       <= '0;
            wr_en     <= 1'b1;
            state     <= SCAN;
          end
        end

        SCAN: begin
          if (!at_last) begin
            sel <= sel + SEL_W'(1);
          end else if (strobe) begin
            // Back-to-back scan: restart with no idle gap.
            numch_lat <= clamp_numch(numch);
            sel       <= '0;
            wr_en     <= 1'b1;
          end else begin
            sel   <= '0;
            wr_en <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          sel   <= '0;
          wr_en <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decode taken only from registered state, so it is stable per cycle.
  assign channel = wr_en ? sel_onehot(sel) : '0;
  assign first   = wr_en && (sel == '0);
  assign last    = wr_en && at_last;
  assign busy    = (state == SCAN);

endmodule

// File: tb/tb_ch_mux_seq.sv
// Directed bench for ch_mux_seq: single scans, back-to-back scans, overrun
// set/clear, numch clamping, mid-scan numch changes and reset mid-scan.
module tb_ch_mux_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        strobe;
  logic [3:0]  numch;
  logic        clr_ovr;
  logic [2:0]  sel;
  logic        wr_en;
  logic [7:0]  channel;
  logic        first;
  logic        last;
  logic        busy;
  logic        overrun;

  int n_checks = 0;
  int n_errors = 0;

  // Combinational 8:1 mux stand-in with input k carrying the value k+1.
  logic [15:0] mux_in [8];
  logic [15:0] dout;
  assign dout = mux_in[sel];

  ch_mux_seq dut (
    .clk     (clk),
    .rst     (rst),
    .strobe  (strobe),
    .numch   (numch),
    .clr_ovr (clr_ovr),
    .sel     (sel),
    .wr_en   (wr_en),
    .channel (channel),
    .first   (first),
    .last    (last),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled at the negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_word(input string tag, input int s, input int n);
    check({tag, " sel"},     32'(sel),     32'(s));
    check({tag, " wr_en"},   32'(wr_en),   32'd1);
    check({tag, " channel"}, 32'(channel), 32'(1) << s);
    check({tag, " first"},   32'(first),   32'(s == 0));
    check({tag, " last"},    32'(last),    32'(s == n - 1));
    check({tag, " busy"},    32'(busy),    32'd1);
    check({tag, " dout"},    32'(dout),    32'(s + 1));
  endtask

  task automatic expect_idle(input string tag);
    check({tag, " sel"},     32'(sel),     32'd0);
    check({tag, " wr_en"},   32'(wr_en),   32'd0);
    check({tag, " channel"}, 32'(channel), 32'd0);
    check({tag, " first"},   32'(first),   32'd0);
    check({tag, " last"},    32'(last),    32'd0);
    check({tag, " busy"},    32'(busy),    32'd0);
  endtask

  // Pulse strobe for one cycle, then follow a full n-word scan back to idle.
  task automatic strobe_scan(input string tag, input int n);
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    for (int s = 0; s < n; s++) begin
      if (s > 0) step();
      expect_word($sformatf("%s w%0d", tag, s), s, n);
    end
    step();
    expect_idle({tag, " end"});
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mux_in[i] = 16'(i + 1);
    rst     = 1'b1;
    strobe  = 1'b0;
    numch   = 4'd8;
    clr_ovr = 1'b0;
    @(negedge clk);
    step();
    rst = 1'b0;

    // Reset state.
    expect_idle("reset");
    check("reset overrun", 32'(overrun), 32'd0);

    // Single 8-channel scan.
    numch = 4'd8;
    strobe_scan("scan8", 8);
    check("scan8 overrun", 32'(overrun), 32'd0);

    // numch=3 with a strobe every 3 cycles: continuous writes.
    numch = 4'd3;
    for (int k = 0; k < 9; k++) begin
      strobe = (k % 3 == 0);
      step();
      strobe = 1'b0;
      expect_word($sformatf("b2b k%0d", k), k % 3, 3);
      check($sformatf("b2b ovr k%0d", k), 32'(overrun), 32'd0);
    end
    step();
    expect_idle("b2b end");

    // numch=1: strobe every cycle is accepted, never an overrun.
    numch = 4'd1;
    strobe = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      expect_word($sformatf("one k%0d", k), 0, 1);
      check($sformatf("one ovr k%0d", k), 32'(overrun), 32'd0);
    end
    strobe = 1'b0;
    step();
    expect_idle("one end");

    // Early second strobe is dropped; first scan completes untouched.
    numch = 4'd8;
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    expect_word("ovr w0", 0, 8);
    for (int s = 1; s < 8; s++) begin
      strobe = (s == 4);
      step();
      strobe = 1'b0;
      expect_word($sformatf("ovr w%0d", s), s, 8);
      check($sformatf("ovr flag w%0d", s), 32'(overrun), 32'(s >= 4));
    end
    step();
    expect_idle("ovr end");
    check("ovr sticky", 32'(overrun), 32'd1);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    check("ovr cleared", 32'(overrun), 32'd0);

    // Clear coincident with a new drop: set wins.
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    expect_word("setwin w0", 0, 8);
    strobe  = 1'b1;
    clr_ovr = 1'b1;
    step();
    strobe  = 1'b0;
    clr_ovr = 1'b0;
    expect_word("setwin w1", 1, 8);
    check("setwin ovr", 32'(overrun), 32'd1);
    for (int s = 2; s < 8; s++) begin
      step();
      expect_word($sformatf("setwin w%0d", s), s, 8);
    end
    step();
    expect_idle("setwin end");
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    check("setwin cleared", 32'(overrun), 32'd0);

    // Clamp: 0 -> one word, 12 -> eight words.
    numch = 4'd0;
    strobe_scan("clamp0", 1);
    numch = 4'd12;
    strobe_scan("clamp12", 8);

    // numch change mid-scan only applies to the next accepted strobe.
    numch = 4'd8;
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    numch  = 4'd2;
    expect_word("mid w0", 0, 8);
    for (int s = 1; s < 8; s++) begin
      step();
      expect_word($sformatf("mid w%0d", s), s, 8);
    end
    step();
    expect_idle("mid end");
    strobe_scan("mid next", 2);

    // Reset mid-scan aborts immediately and clears overrun.
    numch = 4'd8;
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    expect_word("rst w0", 0, 8);
    step();
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    check("rst pre ovr", 32'(overrun), 32'd1);
    step();
    step();
    expect_word("rst w4", 4, 8);
    rst = 1'b1;
    step();
    expect_idle("rst abort");
    check("rst abort ovr", 32'(overrun), 32'd0);
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    expect_idle("rst strobe ignored");
    rst = 1'b0;
    step();
    expect_idle("rst released");
    strobe_scan("post rst", 8);
    check("post rst ovr", 32'(overrun), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
